dds_sweep_controller: RTL and testbench

- Sequencing/configuration controller for the DDS waveform generators.
- Owns the phase accumulator and drives the 7-bit ROM address (with phase offset) to the waveform ROMs.
- Steps the frequency tuning word from a start value to a stop value, holding each step for a programmable dwell.
- Supports single, triangle-repeat and sawtooth-repeat sweeps, plus a waveform select for the downstream output mux.

---
 rtl/dds_pkg.sv | 25 ++
 rtl/dds_phase_accumulator.sv | 42 ++++
 rtl/dds_sweep_controller.sv | 190 +++++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared types and encodings for the DDS sweep controller slice:
//   state_e   - sweep FSM states (IDLE, DWELL, DONE)
//   MODE_*    - sweep mode encodings (value 3 is reserved and behaves as single)
//   WAVE_*    - waveform select encodings for the downstream output mux
// -----------------------------------------------------------------------------
package dds_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_TRI    = 2'd1;
   localparam logic [1:0] MODE_SAW    = 2'd2;

   localparam logic [1:0] WAVE_SINE   = 2'd0;
   localparam logic [1:0] WAVE_TRI    = 2'd1;
   localparam logic [1:0] WAVE_SQUARE = 2'd2;
   localparam logic [1:0] WAVE_SAW    = 2'd3;

endpackage

// File: rtl/dds_phase_accumulator.sv
// -----------------------------------------------------------------------------
// dds_phase_accumulator
// Free-running phase accumulator and registered waveform-ROM address.
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   step_i       in   tuning word added to the accumulator every cycle
//   phase_off_i  in   phase offset added to the ROM address
//   phase_addr_o out  registered ROM address (top ADDR_W bits of acc + offset)
// -----------------------------------------------------------------------------
module dds_phase_accumulator #(
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ACC_W-1:0]  step_i,
   input  logic [ADDR_W-1:0] phase_off_i,
   output logic [ADDR_W-1:0] phase_addr_o
);

   logic [ACC_W-1:0]  acc_q,  acc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // Both sums wrap naturally at their register widths.
   always_comb begin
      acc_d  = acc_q + step_i;
      addr_d = acc_q[ACC_W-1 -: ADDR_W] + phase_off_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         addr_q <= '0;
      end else begin
         acc_q  <= acc_d;
         addr_q <= addr_d;
      end
   end

   assign phase_addr_o = addr_q;

endmodule

// File: rtl/dds_sweep_controller.sv
// -----------------------------------------------------------------------------
// dds_sweep_controller
// Frequency-sweep sequencer for the DDS waveform generators. Steps the tuning
// word from start to stop by delta, holding each value dwell+1 cycles, in
// single, triangle-repeat or sawtooth-repeat mode, and drives the phase
// accumulator / ROM address.
//   clk, reset       clock, asynchronous active-high reset
//   cfg_valid/ready  configuration handshake (ready only in IDLE without abort)
//   cfg_start_step   first tuning word
//   cfg_stop_step    final tuning word
//   cfg_delta        step magnitude
//   cfg_dwell        extra hold cycles per step
//   cfg_mode         0 single, 1 triangle, 2 sawtooth, 3 as single
//   cfg_wave_sel     waveform select, registered on accept
//   cfg_phase        ROM address phase offset, registered on accept
//   abort            terminate sweep, return to IDLE
//   step_out         current tuning word
//   phase_addr       registered ROM address
//   wave_sel         registered waveform select
//   busy             high in DWELL
//   sweep_done       one-cycle pulse on completion of a single-mode sweep
// -----------------------------------------------------------------------------
module dds_sweep_controller
   import dds_pkg::*;
#(
   parameter int unsigned ACC_W   = 16,
   parameter int unsigned ADDR_W  = 7,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [ACC_W-1:0]   cfg_start_step,
   input  logic [ACC_W-1:0]   cfg_stop_step,
   input  logic [ACC_W-1:0]   cfg_delta,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic [1:0]         cfg_wave_sel,
   input  logic [ADDR_W-1:0]  cfg_phase,
   input  logic               abort,
   output logic [ACC_W-1:0]   step_out,
   output logic [ADDR_W-1:0]  phase_addr,
   output logic [1:0]         wave_sel,
   output logic               busy,
   output logic               sweep_done
);

   state_e             state_q,  state_d;
   logic [ACC_W-1:0]   step_q,   step_d;
   logic [ACC_W-1:0]   start_q,  start_d;
   logic [ACC_W-1:0]   target_q, target_d;
   logic [ACC_W-1:0]   delta_q,  delta_d;
   logic [DWELL_W-1:0] reload_q, reload_d;
   logic [DWELL_W-1:0] cnt_q,    cnt_d;
   logic               up_q,     up_d;
   logic [1:0]         mode_q,   mode_d;
   logic [1:0]         wave_q,   wave_d;
   logic [ADDR_W-1:0]  phase_q,  phase_d;

   logic [ACC_W:0]     gap_up, gap_dn;
   logic [ACC_W-1:0]   next_step;
   logic               leg_end;

   // Distance to target in ACC_W+1 bits; when the remaining gap fits inside
   // one delta the step lands exactly on target, so step_out never wraps.
   always_comb begin
      gap_up = {1'b0, target_q} - {1'b0, step_q};
      gap_dn = {1'b0, step_q} - {1'b0, target_q};
      if (up_q) begin
         next_step = (gap_up <= {1'b0, delta_q}) ? target_q : step_q + delta_q;
      end else begin
         next_step = (gap_dn <= {1'b0, delta_q}) ? target_q : step_q - delta_q;
      end
      // delta==0 can never reach target, so it counts as already there.
      leg_end = (step_q == target_q) || (delta_q == '0);
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      start_d    = start_q;
      target_d   = target_q;
      delta_d    = delta_q;
      reload_d   = reload_q;
      cnt_d      = cnt_q;
      up_d       = up_q;
      mode_d     = mode_q;
      wave_d     = wave_q;
      phase_d    = phase_q;
      cfg_ready  = 1'b0;
      busy       = 1'b0;
      sweep_done = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cfg_ready = !abort;
            if (cfg_valid && !abort) begin
               step_d   = cfg_start_step;
               start_d  = cfg_start_step;
               target_d = cfg_stop_step;
               delta_d  = cfg_delta;
               reload_d = cfg_dwell;
               cnt_d    = cfg_dwell;
               up_d     = (cfg_stop_step >= cfg_start_step);
               mode_d   = cfg_mode;
               wave_d   = cfg_wave_sel;
               phase_d  = cfg_phase;
               state_d  = ST_DWELL;
            end
         end

         ST_DWELL: begin
            busy = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (!leg_end) begin
               step_d = next_step;
               cnt_d  = reload_q;
            end else begin
               case (mode_q)
                  MODE_TRI: begin
                     start_d  = target_q;
                     target_d = start_q;
                     up_d     = !up_q;
                     cnt_d    = reload_q;
                  end
                  MODE_SAW: begin
                     step_d = start_q;
                     cnt_d  = reload_q;
                  end
                  default: state_d = ST_DONE;
               endcase
            end
         end

         ST_DONE: begin
            sweep_done = !abort;
            state_d    = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         step_q   <= '0;
         start_q  <= '0;
         target_q <= '0;
         delta_q  <= '0;
         reload_q <= '0;
         cnt_q    <= '0;
         up_q     <= 1'b1;
         mode_q   <= MODE_SINGLE;
         wave_q   <= WAVE_SINE;
         phase_q  <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         start_q  <= start_d;
         target_q <= target_d;
         delta_q  <= delta_d;
         reload_q <= reload_d;
         cnt_q    <= cnt_d;
         up_q     <= up_d;
         mode_q   <= mode_d;
         wave_q   <= wave_d;
         phase_q  <= phase_d;
      end
   end

   dds_phase_accumulator #(
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W)
   ) u_phase_acc (
      .clk          (clk),
      .reset        (reset),
      .step_i       (step_q),
      .phase_off_i  (phase_q),
      .phase_addr_o (phase_addr)
   );

   assign step_out = step_q;
   assign wave_sel = wave_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
module tb_dds_sweep_controller;
   import dds_pkg::*;

   localparam int unsigned ACC_W   = 16;
   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned DWELL_W = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [ACC_W-1:0]   cfg_start_step;
   logic [ACC_W-1:0]   cfg_stop_step;
   logic [ACC_W-1:0]   cfg_delta;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [1:0]         cfg_mode;
   logic [1:0]         cfg_wave_sel;
   logic [ADDR_W-1:0]  cfg_phase;
   logic               abort;
   logic [ACC_W-1:0]   step_out;
   logic [ADDR_W-1:0]  phase_addr;
   logic [1:0]         wave_sel;
   logic               busy;
   logic               sweep_done;

   int checks = 0;
   int errors = 0;

   dds_sweep_controller #(
      .ACC_W   (ACC_W),
      .ADDR_W  (ADDR_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_start_step (cfg_start_step),
      .cfg_stop_step  (cfg_stop_step),
      .cfg_delta      (cfg_delta),
      .cfg_dwell      (cfg_dwell),
      .cfg_mode       (cfg_mode),
      .cfg_wave_sel   (cfg_wave_sel),
      .cfg_phase      (cfg_phase),
      .abort          (abort),
      .step_out       (step_out),
      .phase_addr     (phase_addr),
      .wave_sel       (wave_sel),
      .busy           (busy),
      .sweep_done     (sweep_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic send_cfg(input int start, input int stop, input int delta, input int dwell,
                           input logic [1:0] mode, input logic [1:0] wave, input int phase);
      cfg_start_step = ACC_W'(start);
      cfg_stop_step  = ACC_W'(stop);
      cfg_delta      = ACC_W'(delta);
      cfg_dwell      = DWELL_W'(dwell);
      cfg_mode       = mode;
      cfg_wave_sel   = wave;
      cfg_phase      = ADDR_W'(phase);
      cfg_valid      = 1'b1;
      tick();
      cfg_valid      = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (step_out !== 16'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step_out); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
      checks++; if (busy !== 1'b0 || sweep_done !== 1'b0 || wave_sel !== 2'd0) begin
         errors++; $display("FAIL reset_flags: busy=%b done=%b wave=%0d expected 0 0 0", busy, sweep_done, wave_sel);
      end
      for (int k = 0; k < 4; k++) begin
         checks++; if (phase_addr !== 7'd0) begin errors++; $display("FAIL idle_phase k=%0d: got %0d expected 0", k, phase_addr); end
         tick();
      end
      // mid-sweep reset
      send_cfg(1000, 2000, 100, 0, MODE_TRI, WAVE_SQUARE, 9);
      for (int k = 0; k < 5; k++) tick();
      checks++; if (step_out !== 16'd1500) begin errors++; $display("FAIL pre_reset_step: got %0d expected 1500", step_out); end
      reset = 1'b1;
      #1;
      checks++; if (step_out !== 16'd0 || phase_addr !== 7'd0 || wave_sel !== 2'd0) begin
         errors++; $display("FAIL midreset_data: step=%0d addr=%0d wave=%0d expected 0 0 0", step_out, phase_addr, wave_sel);
      end
      checks++; if (busy !== 1'b0 || sweep_done !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_ctrl: busy=%b done=%b ready=%b expected 0 0 1", busy, sweep_done, cfg_ready);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_up_sweep();
      logic [ACC_W-1:0] exp;
      send_cfg(100, 130, 10, 2, MODE_SINGLE, WAVE_TRI, 0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) tick();
         exp = ACC_W'(100 + 10 * (k / 3));
         checks++; if (step_out !== exp) begin errors++; $display("FAIL up_step k=%0d: got %0d expected %0d", k, step_out, exp); end
         checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0 || sweep_done !== 1'b0) begin
            errors++; $display("FAIL up_ctrl k=%0d: busy=%b ready=%b done=%b expected 1 0 0", k, busy, cfg_ready, sweep_done);
         end
      end
      tick();
      checks++; if (sweep_done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++; $display("FAIL up_done: done=%b busy=%b ready=%b expected 1 0 0", sweep_done, busy, cfg_ready);
      end
      checks++; if (step_out !== 16'd130 || wave_sel !== WAVE_TRI) begin
         errors++; $display("FAIL up_final: step=%0d wave=%0d expected 130 1", step_out, wave_sel);
      end
      tick();
      checks++; if (sweep_done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || step_out !== 16'd130) begin
         errors++; $display("FAIL up_idle: done=%b busy=%b ready=%b step=%0d expected 0 0 1 130", sweep_done, busy, cfg_ready, step_out);
      end
   endtask

   task automatic test_down_clamp();
      int exp_tab[4] = '{50, 30, 10, 3};
      send_cfg(50, 3, 20, 0, MODE_SINGLE, WAVE_SINE, 0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         checks++; if (step_out !== ACC_W'(exp_tab[k]) || busy !== 1'b1) begin
            errors++; $display("FAIL down_step k=%0d: step=%0d busy=%b expected %0d 1", k, step_out, busy, exp_tab[k]);
         end
      end
      tick();
      checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL down_done: got %b expected 1", sweep_done); end
      abort = 1'b1;
      #1;
      checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL done_abort: got %b expected 0", sweep_done); end
      tick();
      abort = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || step_out !== 16'd3 || sweep_done !== 1'b0) begin
         errors++; $display("FAIL down_idle: busy=%b ready=%b step=%0d done=%b expected 0 1 3 0", busy, cfg_ready, step_out, sweep_done);
      end
   endtask

   task automatic test_triangle();
      int exp_tab[8] = '{0, 2, 4, 4, 2, 0, 0, 2};
      send_cfg(0, 4, 2, 0, MODE_TRI, WAVE_SAW, 0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         checks++; if (step_out !== ACC_W'(exp_tab[k]) || sweep_done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL tri_step k=%0d: step=%0d done=%b busy=%b expected %0d 0 1", k, step_out, sweep_done, busy, exp_tab[k]);
         end
      end
      checks++; if (wave_sel !== WAVE_SAW) begin errors++; $display("FAIL tri_wave: got %0d expected 3", wave_sel); end
      abort = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || step_out !== 16'd2 || sweep_done !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++; $display("FAIL tri_abort: busy=%b step=%0d done=%b ready=%b expected 0 2 0 0", busy, step_out, sweep_done, cfg_ready);
      end
      abort = 1'b0;
      #1;
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL tri_ready: got %b expected 1", cfg_ready); end
      tick();
      tick();
      checks++; if (step_out !== 16'd2 || sweep_done !== 1'b0) begin
         errors++; $display("FAIL tri_frozen: step=%0d done=%b expected 2 0", step_out, sweep_done);
      end
   endtask

   task automatic test_sawtooth();
      int exp_tab[7] = '{10, 12, 14, 10, 12, 14, 10};
      send_cfg(10, 14, 2, 0, MODE_SAW, WAVE_SINE, 0);
      for (int k = 0; k < 7; k++) begin
         if (k > 0) tick();
         checks++; if (step_out !== ACC_W'(exp_tab[k]) || sweep_done !== 1'b0) begin
            errors++; $display("FAIL saw_step k=%0d: step=%0d done=%b expected %0d 0", k, step_out, sweep_done, exp_tab[k]);
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL saw_abort: busy=%b expected 0", busy); end
   endtask

   task automatic test_phase(input int offset);
      logic [ADDR_W-1:0] exp;
      do_reset();
      send_cfg(512, 512, 0, 65535, MODE_SINGLE, WAVE_SINE, offset);
      checks++; if (phase_addr !== 7'd0) begin errors++; $display("FAIL phase_first off=%0d: got %0d expected 0", offset, phase_addr); end
      for (int k = 1; k <= 140; k++) begin
         tick();
         exp = ADDR_W'((k - 1 + offset) % 128);
         checks++; if (phase_addr !== exp) begin
            errors++; $display("FAIL phase_addr off=%0d k=%0d: got %0d expected %0d", offset, k, phase_addr, exp);
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_handshake();
      do_reset();
      cfg_start_step = 16'd55;
      cfg_stop_step  = 16'd60;
      cfg_delta      = 16'd1;
      cfg_valid      = 1'b1;
      abort          = 1'b1;
      #1;
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_abort: got %b expected 0", cfg_ready); end
      tick();
      checks++; if (busy !== 1'b0 || step_out !== 16'd0) begin
         errors++; $display("FAIL hs_not_accepted: busy=%b step=%0d expected 0 0", busy, step_out);
      end
      cfg_valid = 1'b0;
      abort     = 1'b0;
      // delta==0, start!=stop: hold start dwell+1 cycles then finish
      send_cfg(7, 9, 0, 1, MODE_SINGLE, WAVE_SQUARE, 0);
      checks++; if (step_out !== 16'd7 || busy !== 1'b1 || wave_sel !== WAVE_SQUARE) begin
         errors++; $display("FAIL hs_accept: step=%0d busy=%b wave=%0d expected 7 1 2", step_out, busy, wave_sel);
      end
      send_cfg(999, 1000, 1, 0, MODE_TRI, WAVE_SINE, 3);
      checks++; if (step_out !== 16'd7 || busy !== 1'b1 || sweep_done !== 1'b0) begin
         errors++; $display("FAIL hs_dwell_ignore: step=%0d busy=%b done=%b expected 7 1 0", step_out, busy, sweep_done);
      end
      tick();
      checks++; if (sweep_done !== 1'b1 || step_out !== 16'd7 || busy !== 1'b0 || wave_sel !== WAVE_SQUARE) begin
         errors++; $display("FAIL hs_degen_done: done=%b step=%0d busy=%b wave=%0d expected 1 7 0 2", sweep_done, step_out, busy, wave_sel);
      end
      tick();
      checks++; if (sweep_done !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++; $display("FAIL hs_idle: done=%b ready=%b expected 0 1", sweep_done, cfg_ready);
      end
   endtask

   initial begin
      reset          = 1'b1;
      cfg_valid      = 1'b0;
      abort          = 1'b0;
      cfg_start_step = '0;
      cfg_stop_step  = '0;
      cfg_delta      = '0;
      cfg_dwell      = '0;
      cfg_mode       = '0;
      cfg_wave_sel   = '0;
      cfg_phase      = '0;
      test_reset();
      test_up_sweep();
      test_down_clamp();
      test_triangle();
      test_sawtooth();
      test_phase(0);
      test_phase(5);
      test_handshake();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
